// File: rtl/demux_1_to_n_hs.sv
// demux_1_to_n_hs: 1-to-N registered demultiplexer with valid/ready on every port.
// Each channel owns its output register, so a stalled consumer only blocks words aimed at it.
module demux_1_to_n_hs #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter bit CLR   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               sel_err,
    output logic [7:0]         drop_cnt
);
    localparam int S = 2 ** SEL_W;
    logic [S-1:0] w_ch_ready;
    logic         w_bad_sel;
    logic         w_xfer;
    logic         r_sel_err;
    logic [7:0]   r_drop_cnt;
    genvar k;
    // Unused select codes read as always-ready so out-of-range words are swallowed.
    generate
        for (k = 0; k < S; k++) begin : g_rdy
            if (k < N) begin : g_real
                assign w_ch_ready[k] = !out_valid[k] || out_ready[k];
            end else begin : g_pad
                assign w_ch_ready[k] = 1'b1;
            end
        end
    endgenerate
    assign w_bad_sel = {1'b0, sel} >= (SEL_W + 1)'(N);
    assign in_ready  = w_ch_ready[sel];
    assign w_xfer    = in_valid && in_ready;
    generate
        for (k = 0; k < N; k++) begin : g_chan
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_load;
            logic             w_drain;
            assign w_load  = w_xfer && sel == SEL_W'(k);
            assign w_drain = r_valid && out_ready[k];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                    r_data  <= CLR ? '0 : r_data;
                end
            end
            assign out_valid[k]                 = r_valid;
            assign out_data[k*WIDTH +: WIDTH] = r_data;
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_sel_err <= w_xfer && w_bad_sel;
            if (w_xfer && w_bad_sel && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
    assign sel_err  = r_sel_err;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_demux_1_to_n_hs.sv
// tb_demux_1_to_n_hs: two instances (N=4/CLR=0 and N=3/CLR=1) checked against a slot-per-channel model.
module tb_demux_1_to_n_hs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv   [2];
    logic [1:0] sl   [2];
    logic [7:0] idat [2];
    logic [3:0] ordy [2];

    logic        ird0, serr0, ird3, serr3;
    logic [7:0]  dcnt0, dcnt3;
    logic [3:0]  ov0;
    logic [2:0]  ov3;
    logic [31:0] od0;
    logic [23:0] od3;

    int checks = 0;
    int errors = 0;

    demux_1_to_n_hs #(.WIDTH(8), .N(4), .SEL_W(2), .CLR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird0), .in_data(idat[0]),
        .sel(sl[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
        .sel_err(serr0), .drop_cnt(dcnt0));

    demux_1_to_n_hs #(.WIDTH(8), .N(3), .SEL_W(2), .CLR(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird3), .in_data(idat[1]),
        .sel(sl[1]), .out_valid(ov3), .out_ready(ordy[1][2:0]), .out_data(od3),
        .sel_err(serr3), .drop_cnt(dcnt3));

    function automatic logic [3:0] f_ov(int i);
        return i == 0 ? ov0 : {1'b0, ov3};
    endfunction
    function automatic logic [31:0] f_od(int i);
        return i == 0 ? od0 : {8'h00, od3};
    endfunction
    function automatic logic f_rdy(int i);
        return i == 0 ? ird0 : ird3;
    endfunction
    function automatic logic f_err(int i);
        return i == 0 ? serr0 : serr3;
    endfunction
    function automatic logic [7:0] f_cnt(int i);
        return i == 0 ? dcnt0 : dcnt3;
    endfunction

    task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Reference: one holding slot per channel plus a drop counter.
    int         nch  [2] = '{4, 3};
    bit         clrp [2] = '{1'b0, 1'b1};
    logic [7:0] m_data [2][4];
    bit         m_vld  [2][4];
    bit         m_err  [2];
    int         m_drops[2];

    function automatic bit m_ready(int i);
        return int'(sl[i]) >= nch[i] || !m_vld[i][sl[i]] || ordy[i][sl[i]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 4; k++) begin
                    m_vld[i][k]  <= 1'b0;
                    m_data[i][k] <= 8'h00;
                end
                m_err[i]   <= 1'b0;
                m_drops[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit tr;
                bit bad;
                tr  = iv[i] && m_ready(i);
                bad = int'(sl[i]) >= nch[i];
                for (int k = 0; k < nch[i]; k++) begin
                    if (tr && int'(sl[i]) == k) begin
                        m_vld[i][k]  <= 1'b1;
                        m_data[i][k] <= idat[i];
                    end else if (m_vld[i][k] && ordy[i][k]) begin
                        m_vld[i][k] <= 1'b0;
                        if (clrp[i]) m_data[i][k] <= 8'h00;
                    end
                end
                m_err[i] <= tr && bad;
                if (tr && bad) m_drops[i] <= m_drops[i] < 255 ? m_drops[i] + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] ev;
                ev = 4'b0000;
                for (int k = 0; k < nch[i]; k++) begin
                    ev[k] = m_vld[i][k];
                    check("out_data", i, {24'h0, f_od(i)[k*8 +: 8]}, {24'h0, m_data[i][k]});
                end
                check("in_ready", i, {31'h0, f_rdy(i)}, {31'h0, m_ready(i)});
                check("out_valid", i, {28'h0, f_ov(i)}, {28'h0, ev});
                check("sel_err", i, {31'h0, f_err(i)}, {31'h0, m_err[i]});
                check("drop_cnt", i, {24'h0, f_cnt(i)}, m_drops[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, bit v, int s, int d, int r);
        iv[i]   = v;
        sl[i]   = s[1:0];
        idat[i] = d[7:0];
        ordy[i] = r[3:0];
        #1;
    endtask

    initial begin
        iv   = '{1'b0, 1'b0};
        sl   = '{2'd0, 2'd0};
        idat = '{8'h00, 8'h00};
        ordy = '{4'h0, 4'h0};
        #1;
        check("rst_ov", 0, {28'h0, ov0}, 0);
        check("rst_od", 0, od0, 0);
        check("rst_cnt", 1, {24'h0, dcnt3}, 0);
        check("rst_err", 1, {31'h0, serr3}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(0, 1, 2, 8'hA5, 4'hF);
        step();
        drive(0, 0, 0, 0, 4'hF);
        check("t1_ov", 0, {28'h0, ov0}, 32'h4);
        check("t1_data", 0, {24'h0, od0[23:16]}, 32'hA5);
        step();
        check("t1_clear", 0, {28'h0, ov0}, 0);

        drive(0, 1, 1, 8'h11, 4'b1101);
        step();
        drive(0, 1, 1, 8'h22, 4'b1101);
        check("t2_stall", 0, {31'h0, ird0}, 0);
        check("t2_hold", 0, {24'h0, od0[15:8]}, 32'h11);
        step();
        step();
        check("t2_still", 0, {31'h0, ird0}, 0);
        check("t2_keep", 0, {24'h0, od0[15:8]}, 32'h11);
        drive(0, 1, 3, 8'h33, 4'b1101);
        check("t3_ready", 0, {31'h0, ird0}, 1);
        step();
        check("t3_ov", 0, {28'h0, ov0}, 32'hA);
        check("t3_ch3", 0, {24'h0, od0[31:24]}, 32'h33);
        check("t3_ch1", 0, {24'h0, od0[15:8]}, 32'h11);
        drive(0, 1, 1, 8'h22, 4'b1101);
        check("t2_restall", 0, {31'h0, ird0}, 0);
        step();
        check("t3_drain", 0, {28'h0, ov0}, 32'h2);
        drive(0, 1, 1, 8'h22, 4'hF);
        check("t2_release", 0, {31'h0, ird0}, 1);
        step();
        check("t2_ch1", 0, {24'h0, od0[15:8]}, 32'h22);
        check("t2_ov", 0, {28'h0, ov0}, 32'h2);
        drive(0, 0, 0, 0, 4'hF);
        step();
        check("t2_empty", 0, {28'h0, ov0}, 0);

        drive(1, 1, 3, 8'h77, 3'b111);
        check("t4_ready", 1, {31'h0, ird3}, 1);
        step();
        drive(1, 0, 0, 0, 3'b111);
        check("t4_ov", 1, {29'h0, ov3}, 0);
        check("t4_err", 1, {31'h0, serr3}, 1);
        check("t4_cnt", 1, {24'h0, dcnt3}, 1);
        step();
        check("t4_pulse", 1, {31'h0, serr3}, 0);
        for (int j = 0; j < 300; j++) begin
            drive(1, 1, 3, j, 3'b111);
            step();
        end
        drive(1, 0, 0, 0, 3'b111);
        step();
        check("t4_sat", 1, {24'h0, dcnt3}, 32'hFF);

        for (int j = 0; j < 16; j++) begin
            drive(0, 1, j % 4, j * 7 + 1, 4'hF);
            check("t5_ready", 0, {31'h0, ird0}, 1);
            step();
            check("t5_ov", 0, {28'h0, ov0}, 1 << (j % 4));
            check("t5_data", 0, {24'h0, od0[(j%4)*8 +: 8]}, (j * 7 + 1) & 8'hFF);
        end
        drive(0, 0, 0, 0, 4'hF);
        step();

        drive(0, 1, 0, 8'hC0, 0);
        step();
        drive(0, 1, 3, 8'hC3, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("t6_ov", 0, {28'h0, ov0}, 32'h9);
        check("t6_data", 0, od0 & 32'hFF0000FF, 32'hC30000C0);
        drive(1, 1, 1, 8'h5A, 0);
        step();
        drive(1, 0, 0, 0, 0);
        check("t6_load", 1, {24'h0, od3[15:8]}, 32'h5A);
        drive(1, 0, 0, 0, 3'b111);
        step();
        check("t6_clr_ov", 1, {29'h0, ov3}, 0);
        check("t6_clr", 1, {8'h0, od3}, 0);
        drive(1, 1, 2, 8'h6B, 0);
        step();
        drive(1, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_ov", 0, {28'h0, ov0}, 0);
        check("t6_rst_od", 0, od0, 0);
        check("t6_rst_ov3", 1, {29'h0, ov3}, 0);
        check("t6_rst_od3", 1, {8'h0, od3}, 0);
        check("t6_rst_cnt", 1, {24'h0, dcnt3}, 0);
        step();
        step();
        rst_n = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                int r;
                r = 0;
                for (int k = 0; k < 4; k++) r[k] = $urandom_range(0, 3) != 0;
                if (i == 1) r[3] = 1'b0;
                drive(i, $urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom, r);
            end
            step();
        end
        drive(0, 0, 0, 0, 4'hF);
        drive(1, 0, 0, 0, 3'b111);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
